// File: rtl/fan_speed_ctrl.sv
// -----------------------------------------------------------------------------
// fan_speed_ctrl
//
// Purpose:
//   Temperature-driven fan controller. Each valid temperature sample can move
//   a five-level state machine (OFF/LOW/MED/HIGH/ALARM). Moves up take effect
//   at once and may skip levels. Moves down go one level at a time and only
//   once the temperature is HYST degrees below the on-threshold of the
//   current level. Each level has a target duty. The registered speed output
//   slews toward that target by at most STEP every RAMP_DIV cycles. The one
//   exception is entry into ALARM, which forces full speed immediately.
//
// Ports:
//   clk        in   1  clock, all state updates on the rising edge
//   arst       in   1  asynchronous reset, active low
//   temp_valid in   1  qualifies temp for one cycle
//   temp       in   8  unsigned temperature sample (degrees C)
//   speed      out  8  registered duty value for the downstream PWM stage
//   level      out  3  registered level code: OFF=0 LOW=1 MED=2 HIGH=3 ALARM=4
//   alarm      out  1  high while level is ALARM
//   at_target  out  1  high when speed equals the target of the current level
// -----------------------------------------------------------------------------
module fan_speed_ctrl #(
  parameter int T_LOW    = 25,
  parameter int T_MED    = 30,
  parameter int T_HIGH   = 35,
  parameter int T_ALARM  = 45,
  parameter int HYST     = 2,
  parameter int SPD_LOW  = 64,
  parameter int SPD_MED  = 128,
  parameter int SPD_HIGH = 192,
  parameter int RAMP_DIV = 4,
  parameter int STEP     = 8
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       temp_valid,
  input  logic [7:0] temp,
  output logic [7:0] speed,
  output logic [2:0] level,
  output logic       alarm,
  output logic       at_target
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  if (!(HYST >= 0 && HYST < T_LOW && T_LOW < T_MED && T_MED < T_HIGH &&
        T_HIGH < T_ALARM && T_ALARM <= 255)) begin : g_bad_thresholds
    $error("fan_speed_ctrl: thresholds must satisfy 0 <= HYST < T_LOW < T_MED < T_HIGH < T_ALARM <= 255");
  end

  if (!(SPD_LOW >= 0 && SPD_LOW <= 255 && SPD_MED >= 0 && SPD_MED <= 255 &&
        SPD_HIGH >= 0 && SPD_HIGH <= 255)) begin : g_bad_speeds
    $error("fan_speed_ctrl: level speeds must fit in 8 bits");
  end

  if (!(RAMP_DIV >= 1 && STEP >= 1 && STEP <= 255)) begin : g_bad_ramp
    $error("fan_speed_ctrl: RAMP_DIV must be >= 1 and STEP must be in 1..255");
  end

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    LVL_OFF   = 3'd0,
    LVL_LOW   = 3'd1,
    LVL_MED   = 3'd2,
    LVL_HIGH  = 3'd3,
    LVL_ALARM = 3'd4
  } level_e;

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  localparam logic [7:0] STEP_8  = 8'(STEP);
  localparam logic [7:0] HYST_8  = 8'(HYST);
  localparam logic [7:0] SPD_L_8 = 8'(SPD_LOW);
  localparam logic [7:0] SPD_M_8 = 8'(SPD_MED);
  localparam logic [7:0] SPD_H_8 = 8'(SPD_HIGH);

  // On-thresholds packed low level first: byte 0 = LOW ... byte 3 = ALARM.
  localparam logic [31:0] ON_PACK = {8'(T_ALARM), 8'(T_HIGH), 8'(T_MED), 8'(T_LOW)};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  level_e           state_reg, state_next;
  logic [7:0]       speed_reg, speed_next;
  logic [CNT_W-1:0] ramp_cnt_reg, ramp_cnt_next;

  // ---------------------------------------------------------------------------
  // Threshold comparators: above_on[gi] is set when temp reaches the
  // on-threshold of level gi+1.
  // ---------------------------------------------------------------------------
  logic [3:0] above_on;

  for (genvar gi = 0; gi < 4; gi++) begin : g_on_cmp
    assign above_on[gi] = (temp >= ON_PACK[gi*8 +: 8]);
  end

  // Highest level whose on-threshold is reached. The thresholds are strictly
  // increasing, so above_on is a thermometer code. Scanning from the top
  // keeps the result correct even so.
  level_e up_level;

  always_comb begin
    up_level = LVL_OFF;
    if (above_on[3]) begin
      up_level = LVL_ALARM;
    end else if (above_on[2]) begin
      up_level = LVL_HIGH;
    end else if (above_on[1]) begin
      up_level = LVL_MED;
    end else if (above_on[0]) begin
      up_level = LVL_LOW;
    end
  end

  // The down threshold for the current level is its on-threshold minus HYST.
  // Because HYST < T_LOW, this cannot underflow for any level above OFF.
  // In OFF the value is never consulted.
  logic [7:0] on_cur;
  logic [7:0] down_thr;

  always_comb begin
    on_cur = 8'd0;
    case (state_reg)
      LVL_LOW:   on_cur = ON_PACK[7:0];
      LVL_MED:   on_cur = ON_PACK[15:8];
      LVL_HIGH:  on_cur = ON_PACK[23:16];
      LVL_ALARM: on_cur = ON_PACK[31:24];
      default:   on_cur = 8'd0;
    endcase
  end

  assign down_thr = on_cur - HYST_8;

  // ---------------------------------------------------------------------------
  // Level FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (temp_valid) begin
      if (up_level > state_reg) begin
        state_next = up_level;
      end else if ((state_reg != LVL_OFF) && (temp < down_thr)) begin
        state_next = level_e'(state_reg - 3'd1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Target speed of the registered level
  // ---------------------------------------------------------------------------
  logic [7:0] target_val;

  always_comb begin
    target_val = 8'd0;
    case (state_reg)
      LVL_LOW:   target_val = SPD_L_8;
      LVL_MED:   target_val = SPD_M_8;
      LVL_HIGH:  target_val = SPD_H_8;
      LVL_ALARM: target_val = 8'd255;
      default:   target_val = 8'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Speed ramp
  // The step is min(STEP, |target - speed|), so the final step lands exactly
  // on the target and can never wrap past 0 or 255. Direction is decided
  // again at every step. A target change in mid-ramp therefore only changes
  // the direction, and the counter phase is left alone.
  // ---------------------------------------------------------------------------
  logic [7:0] diff;
  logic [7:0] step_amt;
  logic       ramp_up;

  assign ramp_up  = (target_val > speed_reg);
  assign diff     = ramp_up ? (target_val - speed_reg) : (speed_reg - target_val);
  assign step_amt = (diff < STEP_8) ? diff : STEP_8;

  always_comb begin
    speed_next    = speed_reg;
    ramp_cnt_next = ramp_cnt_reg;
    if ((state_next == LVL_ALARM) && (state_reg != LVL_ALARM)) begin
      // Entering ALARM: jump straight to full speed.
      speed_next    = 8'd255;
      ramp_cnt_next = '0;
    end else if (speed_reg == target_val) begin
      ramp_cnt_next = '0;
    end else if (ramp_cnt_reg == CNT_LAST) begin
      ramp_cnt_next = '0;
      speed_next    = ramp_up ? (speed_reg + step_amt) : (speed_reg - step_amt);
    end else begin
      ramp_cnt_next = ramp_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_reg    <= LVL_OFF;
      speed_reg    <= 8'd0;
      ramp_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      speed_reg    <= speed_next;
      ramp_cnt_reg <= ramp_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // at_target depends only on registered values. In reset both speed and
  // the OFF target are 0, so at_target reads 1.
  // ---------------------------------------------------------------------------
  assign speed     = speed_reg;
  assign level     = state_reg;
  assign alarm     = (state_reg == LVL_ALARM);
  assign at_target = (speed_reg == target_val);

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fan_speed_ctrl
//
// Purpose:
//   Self-checking bench for fan_speed_ctrl. A cycle-level reference model
//   computes the expected outputs for every driven cycle. Those results are
//   pushed to a scoreboard queue and popped after the clock edge for
//   comparison. Fixed-value checks are added at the scenario points where
//   the expected values are known in advance.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_fan_speed_ctrl;

  localparam int T_LOW    = 25;
  localparam int T_MED    = 30;
  localparam int T_HIGH   = 35;
  localparam int T_ALARM  = 45;
  localparam int HYST     = 2;
  localparam int SPD_LOW  = 64;
  localparam int SPD_MED  = 128;
  localparam int SPD_HIGH = 192;
  localparam int RAMP_DIV = 4;
  localparam int STEP     = 8;

  logic       clk = 1'b0;
  logic       arst;
  logic       temp_valid;
  logic [7:0] temp;
  logic [7:0] speed;
  logic [2:0] level;
  logic       alarm;
  logic       at_target;

  fan_speed_ctrl #(
    .T_LOW(T_LOW), .T_MED(T_MED), .T_HIGH(T_HIGH), .T_ALARM(T_ALARM),
    .HYST(HYST), .SPD_LOW(SPD_LOW), .SPD_MED(SPD_MED), .SPD_HIGH(SPD_HIGH),
    .RAMP_DIV(RAMP_DIV), .STEP(STEP)
  ) dut (
    .clk(clk),
    .arst(arst),
    .temp_valid(temp_valid),
    .temp(temp),
    .speed(speed),
    .level(level),
    .alarm(alarm),
    .at_target(at_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    int spd;
    int alm;
    int at;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_state = 0;
  int m_speed = 0;
  int m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int on_of(input int l);
    case (l)
      1: return T_LOW;
      2: return T_MED;
      3: return T_HIGH;
      4: return T_ALARM;
      default: return 0;
    endcase
  endfunction

  function automatic int tgt_of(input int l);
    case (l)
      1: return SPD_LOW;
      2: return SPD_MED;
      3: return SPD_HIGH;
      4: return 255;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit v, input int t);
    int nst;
    int up;
    int tgt;
    int gap;
    nst = m_state;
    up  = 0;
    tgt = tgt_of(m_state);
    if (v) begin
      for (int l = 1; l <= 4; l++) begin
        if (t >= on_of(l)) up = l;
      end
      if (up > m_state) nst = up;
      else if (m_state != 0 && t < on_of(m_state) - HYST) nst = m_state - 1;
    end
    if (nst == 4 && m_state != 4) begin
      m_speed = 255;
      m_cnt   = 0;
    end else if (m_speed == tgt) begin
      m_cnt = 0;
    end else if (m_cnt == RAMP_DIV - 1) begin
      m_cnt = 0;
      gap = (tgt > m_speed) ? tgt - m_speed : m_speed - tgt;
      if (gap > STEP) gap = STEP;
      m_speed = (tgt > m_speed) ? m_speed + gap : m_speed - gap;
    end else begin
      m_cnt++;
    end
    m_state = nst;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_speed = 0;
    m_cnt   = 0;
    exp_q.delete();
  endtask

  // Drive one cycle (entered 1 time unit after a rising edge), push the
  // expected result, wait for the edge and then compare against the popped
  // expectation.
  task automatic cycle(input bit v, input int t, input string tag);
    exp_t e;
    temp_valid = v;
    temp       = t[7:0];
    model_step(v, t);
    e.lvl = m_state;
    e.spd = m_speed;
    e.alm = (m_state == 4) ? 1 : 0;
    e.at  = (m_speed == tgt_of(m_state)) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".level"}, 32'(level), e.lvl);
    check({tag, ".speed"}, 32'(speed), e.spd);
    check({tag, ".alarm"}, 32'(alarm), e.alm);
    check({tag, ".at_target"}, 32'(at_target), e.at);
    if (v) begin
      $display("txn %s: temp=%0d -> level=%0d speed=%0d alarm=%0b at_target=%0b",
               tag, t, level, speed, alarm, at_target);
    end
    temp_valid = 1'b0;
  endtask

  // Invalid cycle carrying a random temperature, which must be ignored.
  task automatic idle();
    cycle(1'b0, int'($urandom_range(0, 90)), "idle");
  endtask

  initial begin
    arst       = 1'b1;
    temp_valid = 1'b0;
    temp       = 8'd0;
    #1 arst = 1'b0;
    #1;
    check("rst.level", 32'(level), 0);
    check("rst.speed", 32'(speed), 0);
    check("rst.alarm", 32'(alarm), 0);
    check("rst.at_target", 32'(at_target), 1);
    model_reset();
    #2 arst = 1'b1;

    // Cool sample keeps the fan off.
    cycle(1'b1, 20, "t20");
    check("t20.level_const", 32'(level), 0);

    // Jump OFF -> MED and ramp to 128.
    cycle(1'b1, 31, "t31");
    check("t31.level_const", 32'(level), 2);
    for (int i = 1; i <= 64; i++) begin
      idle();
      if (i == 4)  check("med_first_step", 32'(speed), 8);
      if (i == 63) check("med_not_yet", 32'(at_target), 0);
    end
    check("med_ramp_done", 32'(speed), 128);
    check("med_at_target", 32'(at_target), 1);

    // Hysteresis on the way down.
    cycle(1'b1, 29, "t29");
    check("t29.hold_med", 32'(level), 2);
    cycle(1'b1, 27, "t27");
    check("t27.to_low", 32'(level), 1);
    repeat (40) idle();
    check("low_ramp_done", 32'(speed), 64);

    // Alarm bypass and ramp down from 255.
    cycle(1'b1, 50, "t50");
    check("t50.level", 32'(level), 4);
    check("t50.alarm", 32'(alarm), 1);
    check("t50.speed", 32'(speed), 255);
    cycle(1'b1, 44, "t44");
    check("t44.hold_alarm", 32'(level), 4);
    cycle(1'b1, 42, "t42");
    check("t42.level", 32'(level), 3);
    check("t42.alarm", 32'(alarm), 0);
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (i == 4)  check("high_first_down", 32'(speed), 247);
      if (i == 28) check("high_step_199", 32'(speed), 199);
    end
    check("high_ramp_done", 32'(speed), 192);

    // Hot sample with temp_valid low has no effect.
    repeat (3) cycle(1'b0, 60, "invalid_hot");
    check("invalid.level", 32'(level), 3);
    check("invalid.speed", 32'(speed), 192);

    // Threshold boundaries and mid-ramp reversal.
    cycle(1'b1, 33, "t33_edge_hold");
    cycle(1'b1, 32, "t32_down");
    check("t32.level", 32'(level), 2);
    repeat (6) idle();
    cycle(1'b1, 36, "t36_reverse");
    repeat (20) idle();
    cycle(1'b1, 35, "t35_exact");
    cycle(1'b1, 45, "t45_exact_alarm");
    check("t45.level", 32'(level), 4);
    cycle(1'b1, 43, "t43_edge_hold");
    check("t43.level", 32'(level), 4);

    // Random traffic against the model.
    repeat (200) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 70)), "rand");
    end

    // Asynchronous reset in the middle of a ramp-down.
    cycle(1'b1, 50, "pre_rst_alarm");
    cycle(1'b1, 40, "pre_rst_high");
    repeat (6) idle();
    #2 arst = 1'b0;
    #1;
    check("arst.level", 32'(level), 0);
    check("arst.speed", 32'(speed), 0);
    check("arst.alarm", 32'(alarm), 0);
    check("arst.at_target", 32'(at_target), 1);
    model_reset();
    #1 arst = 1'b1;
    cycle(1'b1, 20, "post_rst_t20");
    check("post_rst.level", 32'(level), 0);
    cycle(1'b1, 31, "post_rst_t31");
    check("post_rst.level_med", 32'(level), 2);
    check("post_rst.speed", 32'(speed), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
